pll_reset_ctrl: RTL and testbench
=================================

// Module: pll_reset_ctrl
// PURPOSE
//  Reset sequencer downstream of the system PLL wrapper. Runs on the free-running
//  PLL reference clock, drives the PLL's active-high reset, and consumes the PLL's
//  asynchronous locked flag. Qualifies lock with a stability window before
//  releasing the core reset.
//  rst_n_o is re-synchronised by each consuming clock domain.
// PARAMETERS
//  SYNC_STAGES    2      flops in locked_i synchroniser (>=2)
//  RST_CYCLES     16     pll_rst_o pulse width in clk_i cycles (>=1)
//  STABLE_CYCLES  1024   consecutive synced-locked cycles required before release (>=1)
//  LOCK_TIMEOUT   65536  cycles in WAIT_LOCK before a PLL reset retry (>=1)
// PORTS
//  clk_i        in   1  PLL reference clock (free-running)
//  rst_n_i      in   1  asynchronous active-low reset
//  locked_i     in   1  PLL lock flag, asynchronous to clk_i
//  pll_rst_o    out  1  active-high reset to PLL
//  rst_n_o      out  1  active-low core reset, registered
//  retry_cnt_o  out  8  PLL reset retries, saturating (only with macro)
// BEHAVIOUR
//  - Async reset (rst_n_i=0):
//    - pll_rst_o=1, rst_n_o=0, state=PLL_RST.
//    - All counters=0, synchroniser flops=0, retry_cnt_o=0.
//    - Takes effect immediately, regardless of clk_i.
//  - locked_s = locked_i after SYNC_STAGES flops; FSM sees only locked_s.
//  - PLL_RST: pll_rst_o=1 for exactly RST_CYCLES cycles, then ->WAIT_LOCK.
//    Counter cleared on exit. locked_s is ignored in this state.
//  - WAIT_LOCK: pll_rst_o=0, counter increments each cycle.
//    - locked_s=1 -> STABLE, counter cleared.
//    - counter==LOCK_TIMEOUT-1 with locked_s=0 -> retry behaviour (see CONFIGURATION).
//    - locked_s=1 on the timeout cycle: lock wins, ->STABLE.
//  - STABLE: counter counts consecutive locked_s=1 cycles.
//    - locked_s=0 -> WAIT_LOCK, counter cleared; timeout restarts from 0.
//    - counter==STABLE_CYCLES-1 with locked_s=1 -> RUN.
//  - RUN: rst_n_o=1 (registered; set on the edge entering RUN).
//    - locked_s=0 -> WAIT_LOCK and rst_n_o=0 on that same edge. PLL is not reset;
//      Altera PLL re-acquires on its own.
//  - rst_n_o=1 only in RUN; pll_rst_o=1 only in PLL_RST. Both are decoded from
//    registered state: glitch-free, no combinational path from locked_i.
//  - Latency: locked_i high and stable, entering WAIT_LOCK -> rst_n_o rises exactly
//    SYNC_STAGES+STABLE_CYCLES+1 clk_i edges later.
//  - Lock-loss latency: locked_i falling to rst_n_o=0 is at most SYNC_STAGES+1 edges.
//  - Counters: width $clog2(max(RST_CYCLES,STABLE_CYCLES,LOCK_TIMEOUT))+1.
//    One shared counter is allowed; it never wraps.
//  - Unused/illegal state encodings recover to PLL_RST on the next edge.
// CONFIGURATION
//  - PLL_RESET_RETRY_EN defined:
//    - WAIT_LOCK timeout -> PLL_RST (new RST_CYCLES pulse).
//    - retry_cnt_o increments on that edge, saturating at 255.
//  - PLL_RESET_RETRY_EN undefined:
//    - No retry: the timeout counter saturates at LOCK_TIMEOUT-1 and the FSM waits
//      in WAIT_LOCK indefinitely.
//    - retry_cnt_o is tied to 8'd0.
// TESTING (bench params: SYNC_STAGES=2 RST_CYCLES=4 STABLE_CYCLES=8 LOCK_TIMEOUT=32)
//  1. Release rst_n_i, locked_i=1 throughout.
//     -> pll_rst_o=1 for 4 cycles, then 0; rst_n_o rises 11 edges after pll_rst_o falls.
//  2. In STABLE, after 5 locked cycles, pulse locked_i low for 3 cycles.
//     -> rst_n_o stays 0; once locked_i returns high, the full 11-edge interval restarts.
//  3. In RUN, drop locked_i.
//     -> rst_n_o=0 within 3 edges, pll_rst_o stays 0.
//     -> Re-raise locked_i: rst_n_o=1 again 11 edges later.
//  4. Macro on, locked_i=0 forever.
//     -> pll_rst_o is a 4-cycle pulse every 36 cycles; retry_cnt_o counts 1,2,3,...
//     -> Force 300 retries: retry_cnt_o saturates at 255.
//  5. Macro off, locked_i=0 forever.
//     -> Single initial 4-cycle pll_rst_o pulse, then pll_rst_o=0 forever.
//     -> retry_cnt_o=0 throughout.
//     -> Raise locked_i after 1000 cycles: rst_n_o=1 11 edges later.
//  6. Assert rst_n_i mid-RUN, between clk_i edges.
//     -> rst_n_o=0 and pll_rst_o=1 immediately; full sequence repeats after release.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: reset sequencer sitting downstream of the system PLL wrapper.
// Pulses the PLL reset, waits for a synchronised lock, qualifies it over a
// stability window and only then releases the active-low core reset.
// Optional feature macro: PLL_RESET_RETRY_EN (re-pulse the PLL reset when lock
// does not arrive within LOCK_TIMEOUT cycles, and count the retries).
module pll_reset_ctrl #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 65536
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       locked_i,
    output logic       pll_rst_o,
    output logic       rst_n_o,
    output logic [7:0] retry_cnt_o
);

    localparam int unsigned CNT_MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   pll_rst_q, pll_rst_d;
    logic                   rst_n_q, rst_n_d;
`ifdef PLL_RESET_RETRY_EN
    logic                   retry_inc;
    logic [7:0]             retry_q, retry_d;
`endif

    // Lock synchroniser; held clear while the PLL is in reset since its lock
    // flag is meaningless then, so lock is always re-qualified after a pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else if (state_q == PLL_RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked_i};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // State, shared counter and decoded outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            rst_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            rst_n_q   <= rst_n_d;
        end
    end

    // Next-state, counter and output decode; outputs follow the next state so
    // they change on the same edge as the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef PLL_RESET_RETRY_EN
        retry_inc = 1'b0;
`endif
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
`ifdef PLL_RESET_RETRY_EN
                    state_d   = PLL_RST;
                    cnt_d     = '0;
                    retry_inc = 1'b1;
`else
                    cnt_d = cnt_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
        pll_rst_d = (state_d == PLL_RST);
        rst_n_d   = (state_d == RUN);
    end

`ifdef PLL_RESET_RETRY_EN
    // Saturating count of timeout-driven PLL reset retries.
    always_comb begin
        retry_d = retry_q;
        if (retry_inc && (retry_q != 8'hFF)) begin
            retry_d = retry_q + 8'd1;
        end
    end

    // Retry counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            retry_q <= 8'd0;
        end else begin
            retry_q <= retry_d;
        end
    end

    assign retry_cnt_o = retry_q;
`else
    assign retry_cnt_o = 8'd0;
`endif

    assign pll_rst_o = pll_rst_q;
    assign rst_n_o   = rst_n_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench for pll_reset_ctrl. Stimulus pushes the expected output
// transitions (edge number and new output values); a monitor samples outputs on
// the falling clock edge and pops/compares whenever any output changes.
module tb_pll_reset_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       locked_i;
    logic       pll_rst_o;
    logic       rst_n_o;
    logic [7:0] retry_cnt_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic       pll;
        logic       rstn;
        logic [7:0] retry;
    } exp_t;

    exp_t exp_q[$];

    pll_reset_ctrl #(
        .SYNC_STAGES  (2),
        .RST_CYCLES   (4),
        .STABLE_CYCLES(8),
        .LOCK_TIMEOUT (32)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .locked_i   (locked_i),
        .pll_rst_o  (pll_rst_o),
        .rst_n_o    (rst_n_o),
        .retry_cnt_o(retry_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic push(input int c, input logic p, input logic r, input logic [7:0] k);
        exp_t e;
        e.cyc   = c;
        e.pll   = p;
        e.rstn  = r;
        e.retry = k;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, req);
        end
    endtask

    // Monitor: every output change must match the next queued expectation.
    initial begin : monitor
        logic [9:0] prev;
        logic [9:0] cur;
        exp_t       e;
        prev = {1'b1, 1'b0, 8'd0};
        forever begin
            @(negedge clk_i);
            cur = {pll_rst_o, rst_n_o, retry_cnt_o};
            if (cur !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: cyc=%0d pll=%b rstn=%b retry=%0d", cyc,
                             pll_rst_o, rst_n_o, retry_cnt_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.pll !== pll_rst_o || e.rstn !== rst_n_o ||
                        e.retry !== retry_cnt_o) begin
                        bad++;
                        $display("FAIL transition: got cyc=%0d pll=%b rstn=%b retry=%0d want cyc=%0d pll=%b rstn=%b retry=%0d",
                                 cyc, pll_rst_o, rst_n_o, retry_cnt_o, e.cyc, e.pll, e.rstn,
                                 e.retry);
                    end
                end
                prev = cur;
            end
        end
    end

    // Directed stimulus with hand-computed transition edges.
    initial begin : stim
        rst_n_i  = 1'b1;
        locked_i = 1'b1;
        #1 rst_n_i = 1'b0;
        #2;
        check_now("reset_pll_rst", pll_rst_o, 1'b1);
        check_now("reset_rst_n", rst_n_o, 1'b0);

        // Power-up with lock high: 4-cycle PLL pulse, core release 11 edges later.
        tick(3);
        rst_n_i = 1'b1;
        push(7, 1'b0, 1'b0, 8'd0);
        push(18, 1'b0, 1'b1, 8'd0);

        // Lock loss in RUN: core reset within 3 edges, release 11 edges after re-lock.
        wait_cyc(25);
        locked_i = 1'b0;
        push(28, 1'b0, 1'b0, 8'd0);
        tick(5);
        locked_i = 1'b1;
        push(41, 1'b0, 1'b1, 8'd0);

        // Glitch in STABLE: full qualification restarts when lock returns.
        wait_cyc(50);
        locked_i = 1'b0;
        push(53, 1'b0, 1'b0, 8'd0);
        tick(5);
        locked_i = 1'b1;
        wait_cyc(61);
        locked_i = 1'b0;
        tick(3);
        locked_i = 1'b1;
        push(75, 1'b0, 1'b1, 8'd0);

        // Async reset between clock edges mid-RUN, then full sequence again.
        wait_cyc(85);
        push(85, 1'b1, 1'b0, 8'd0);
        rst_n_i = 1'b0;
        #1;
        check_now("async_pll_rst", pll_rst_o, 1'b1);
        check_now("async_rst_n", rst_n_o, 1'b0);
        tick(2);
        rst_n_i = 1'b1;
        push(91, 1'b0, 1'b0, 8'd0);
        push(102, 1'b0, 1'b1, 8'd0);

        // Reset again with the PLL never locking.
        wait_cyc(110);
        push(110, 1'b1, 1'b0, 8'd0);
        rst_n_i  = 1'b0;
        locked_i = 1'b0;
        tick(2);
        rst_n_i = 1'b1;
        push(116, 1'b0, 1'b0, 8'd0);
`ifdef PLL_RESET_RETRY_EN
        // Retry every 36 cycles, counter saturating at 255.
        for (int n = 1; n <= 300; n++) begin
            push(112 + 36 * n, 1'b1, 1'b0, (n > 255) ? 8'd255 : 8'(n));
            push(116 + 36 * n, 1'b0, 1'b0, (n > 255) ? 8'd255 : 8'(n));
        end
        wait_cyc(112 + 36 * 300 + 10);
`else
        // No retry: PLL reset stays low; late lock still releases the core.
        wait_cyc(1116);
        locked_i = 1'b1;
        push(1127, 1'b0, 1'b1, 8'd0);
        wait_cyc(1135);
`endif

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected transitions never seen", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
